uart_tx_ctrl: RTL and testbench

//  Wishbone slave UART transmitter on the openmips_min_sopc data bus. Drives the SoC-level uart_tx pin.
//  CPU stores bytes to TXDATA. They are queued in a small FIFO and serialised 8N1, LSB first.
//  A programmable divisor sets the baud rate.

---
 rtl/openmips_uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 50 +++++
 rtl/uart_tx_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/openmips_uart_pkg.sv
// Shared definitions for the openmips_min_sopc UART transmitter:
// register offsets (word index adr[3:2]), STATUS bit positions and FSM states.
package openmips_uart_pkg;

   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_DIV    = 2'd2;

   localparam int unsigned ST_FULL  = 0;
   localparam int unsigned ST_EMPTY = 1;
   localparam int unsigned ST_BUSY  = 2;
   localparam int unsigned ST_OVF   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmit path.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Pointer update; reset flushes the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage write; contents need no reset since empty gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Wishbone slave UART transmitter: register decode, divisor register,
// TX FIFO and an 8N1 serialiser driving the SoC uart_tx pin.
module uart_tx_ctrl
   import openmips_uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned DEFAULT_DIV = 434,
   parameter int unsigned DIV_W       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        uart_tx
);

   logic             ack_q;
   logic [31:0]      dat_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic             ovf_q;
   uart_tx_state_t   state_q;
   logic [DIV_W-1:0] cnt_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             tx_q;

   logic             access;
   logic             fire;
   logic [1:0]       reg_idx;
   logic             wr_txdata;
   logic             rd_status;
   logic             wr_div;
   logic [31:0]      rd_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_dout;
   logic             tx_pop;
   logic             ovf_set;
   logic [DIV_W-1:0] bit_cycles;
   logic             unused_bits;

   assign access  = wb_cyc_i & wb_stb_i;
   assign fire    = access & ack_q;
   assign reg_idx = wb_adr_i[3:2];

   assign wr_txdata = fire & wb_we_i & (reg_idx == UART_TXDATA) & wb_sel_i[0];
   assign rd_status = fire & ~wb_we_i & (reg_idx == UART_STATUS);
   assign wr_div    = fire & wb_we_i & (reg_idx == UART_DIV);

   assign tx_pop     = ~fifo_empty &
                       ((state_q == IDLE) || ((state_q == STOP) && (cnt_q == '0)));
   assign ovf_set    = wr_txdata & fifo_full & ~tx_pop;
   assign bit_cycles = div_q - DIV_W'(1);

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign uart_tx  = tx_q;

   assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:DIV_W]};

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_txdata),
      .pop_i   (tx_pop),
      .din_i   (wb_dat_i[7:0]),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Read mux: register contents sampled when the ack is raised.
   always_comb begin
      rd_data = '0;
      case (reg_idx)
         UART_STATUS: begin
            rd_data[ST_FULL]  = fifo_full;
            rd_data[ST_EMPTY] = fifo_empty;
            rd_data[ST_BUSY]  = (state_q != IDLE);
            rd_data[ST_OVF]   = ovf_q;
         end
         UART_DIV: rd_data[DIV_W-1:0] = div_q;
         default:  rd_data = '0;
      endcase
   end

   // Divisor next value with byte-lane masking; zero is coerced to one.
   always_comb begin
      div_d = div_q;
      if (wr_div) begin
         if (wb_sel_i[0]) div_d[7:0]       = wb_dat_i[7:0];
         if (wb_sel_i[1]) div_d[DIV_W-1:8] = wb_dat_i[DIV_W-1:8];
         if (div_d == '0) div_d = DIV_W'(1);
      end
   end

   // Bus handshake: ack one cycle after strobe, read data held during ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= access & ~ack_q;
         dat_q <= (access & ~ack_q & ~wb_we_i) ? rd_data : '0;
      end
   end

   // Divisor and sticky overflow; a simultaneous set beats the read-clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= DIV_W'(DEFAULT_DIV);
         ovf_q <= 1'b0;
      end else begin
         div_q <= div_d;
         if (ovf_set)        ovf_q <= 1'b1;
         else if (rd_status) ovf_q <= 1'b0;
      end
   end

   // Transmit FSM: baud counter reloads from div_q at every bit boundary,
   // and STOP chains straight into START when another byte is queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  state_q <= START;
                  shift_q <= fifo_dout;
                  tx_q    <= 1'b0;
                  cnt_q   <= bit_cycles;
               end
            end
            START: begin
               if (cnt_q == '0) begin
                  state_q <= DATA;
                  tx_q    <= shift_q[0];
                  bit_q   <= '0;
                  cnt_q   <= bit_cycles;
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            DATA: begin
               if (cnt_q == '0) begin
                  cnt_q <= bit_cycles;
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            STOP: begin
               if (cnt_q == '0) begin
                  if (!fifo_empty) begin
                     state_q <= START;
                     shift_q <= fifo_dout;
                     tx_q    <= 1'b0;
                     cnt_q   <= bit_cycles;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: register vectors from a table,
// then hand-written frame, back-to-back, overflow, divisor and reset sequences.
module tb_uart_tx_ctrl;

   localparam int LOGN = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [3:0]  adr, sel;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack;
   logic        uart_tx;

   int n_checks = 0;
   int n_fail   = 0;

   logic line_log [LOGN];
   int   cyc_n = 0;

   typedef struct {
      logic        we;
      logic [3:0]  adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [18];

   uart_tx_ctrl #(
      .FIFO_DEPTH  (16),
      .DEFAULT_DIV (434),
      .DIV_W       (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_sel_i (sel),
      .wb_dat_i (dat_i),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack),
      .uart_tx  (uart_tx)
   );

   always #5 clk = ~clk;

   // Record the serial line once per cycle, sampled on the falling edge.
   always @(negedge clk) begin
      if (cyc_n < LOGN) line_log[cyc_n] <= uart_tx;
      cyc_n <= cyc_n + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One single-beat access, started and finished on a falling edge.
   task automatic bus_xfer(input logic w, input logic [3:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rdat, output logic acked);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
      @(posedge clk);
      @(negedge clk);
      acked = ack;
      rdat  = dat_o;
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                     input string name);
      logic [31:0] r;
      logic        k;
      bus_xfer(1'b1, a, s, d, r, k);
      chk({name, " ack"}, {31'b0, k}, 32'd1);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
      logic [31:0] r;
      logic        k;
      bus_xfer(1'b0, a, 4'hF, 32'h0, r, k);
      chk({name, " ack"}, {31'b0, k}, 32'd1);
      chk(name, r, exp);
   endtask

   task automatic wait_low(input string name, output int n0);
      int t;
      t = 0;
      while (uart_tx !== 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk(name, {31'b0, uart_tx}, 32'd0);
      n0 = cyc_n;
   endtask

   // Check one frame in the line log: start bit of d0 cycles, then eight
   // data bits LSB first and a stop bit, each d1 cycles long.
   task automatic check_frame(input int from, input int max_wait, input logic [7:0] b,
                              input int d0, input int d1, output int start);
      int   need, pos, len, hits;
      logic e;
      need = from + max_wait + d0 + 9 * d1;
      while (cyc_n <= need) @(negedge clk);
      start = -1;
      for (int i = from; i <= from + max_wait; i++) begin
         if (start < 0 && line_log[i] == 1'b0) start = i;
      end
      chk($sformatf("frame %02h start found", b), {31'b0, start >= 0}, 32'd1);
      if (start < 0) return;
      pos = start;
      for (int k = 0; k < 10; k++) begin
         len  = (k == 0) ? d0 : d1;
         e    = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
         hits = 0;
         for (int j = 0; j < len; j++) if (line_log[pos + j] == e) hits++;
         chk($sformatf("frame %02h bit %0d samples", b, k), hits, len);
         pos += len;
      end
   endtask

   initial begin
      int          s1, s2, n0, c4, zeros, t;
      logic [31:0] r;
      logic        k;
      logic [7:0]  got [$];
      logic [7:0]  bb;

      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = '0; sel = '0; dat_i = '0;
      repeat (3) @(negedge clk);
      chk("reset uart_tx", {31'b0, uart_tx}, 32'd1);
      chk("reset ack", {31'b0, ack}, 32'd0);
      chk("reset dat_o", dat_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Test 1 and DIV register behaviour.
      vecs[0]  = '{1'b0, 4'h4, 4'hF, 32'h0,        32'h2,    "status after reset"};
      vecs[1]  = '{1'b0, 4'h8, 4'hF, 32'h0,        32'd434,  "div after reset"};
      vecs[2]  = '{1'b0, 4'h0, 4'hF, 32'h0,        32'h0,    "txdata reads zero"};
      vecs[3]  = '{1'b0, 4'hC, 4'hF, 32'h0,        32'h0,    "rsvd reads zero"};
      vecs[4]  = '{1'b1, 4'h8, 4'hF, 32'h0,        32'h0,    "div write 0"};
      vecs[5]  = '{1'b0, 4'h8, 4'hF, 32'h0,        32'h1,    "div 0 stored as 1"};
      vecs[6]  = '{1'b1, 4'h8, 4'h1, 32'h0000ABCD, 32'h0,    "div low lane"};
      vecs[7]  = '{1'b0, 4'h8, 4'hF, 32'h0,        32'hCD,   "div low lane read"};
      vecs[8]  = '{1'b1, 4'h8, 4'h2, 32'h00001200, 32'h0,    "div high lane"};
      vecs[9]  = '{1'b0, 4'h8, 4'hF, 32'h0,        32'h12CD, "div high lane read"};
      vecs[10] = '{1'b1, 4'h8, 4'hF, 32'hFFFF0000, 32'h0,    "div upper bits only"};
      vecs[11] = '{1'b0, 4'h8, 4'hF, 32'h0,        32'h1,    "div zero field as 1"};
      vecs[12] = '{1'b1, 4'hC, 4'hF, 32'hFFFFFFFF, 32'h0,    "rsvd write"};
      vecs[13] = '{1'b0, 4'hC, 4'hF, 32'h0,        32'h0,    "rsvd still zero"};
      vecs[14] = '{1'b0, 4'h4, 4'hF, 32'h0,        32'h2,    "status still empty"};
      vecs[15] = '{1'b1, 4'h0, 4'hE, 32'h77,       32'h0,    "txdata without sel0"};
      vecs[16] = '{1'b0, 4'h4, 4'hF, 32'h0,        32'h2,    "status no push"};
      vecs[17] = '{1'b1, 4'h8, 4'h3, 32'h4,        32'h0,    "div set 4"};
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].we) wr(vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].name);
         else            rd(vecs[i].adr, vecs[i].exp, vecs[i].name);
      end
      chk("line idle after register tests", {31'b0, uart_tx}, 32'd1);

      // Held strobe: ack on alternate cycles, data valid with each ack.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h4; sel = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("held strobe ack %0d", i), {31'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 0) chk($sformatf("held strobe data %0d", i), dat_o, 32'h2);
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);

      // Test 2: one 0xA5 frame at DIV=4.
      s1 = cyc_n;
      wr(4'h0, 4'h1, 32'hA5, "txdata A5");
      check_frame(s1, 20, 8'hA5, 4, 4, s1);
      rd(4'h4, 32'h2, "status after A5 frame");

      // Test 3: two frames back to back with no idle gap.
      s1 = cyc_n;
      wr(4'h0, 4'h1, 32'h55, "txdata 55");
      wr(4'h0, 4'h1, 32'h0F, "txdata 0F");
      rd(4'h4, 32'h4, "status busy one queued");
      check_frame(s1, 20, 8'h55, 4, 4, s1);
      check_frame(s1 + 40, 0, 8'h0F, 4, 4, s2);
      chk("line idle after 80 cycles", {31'b0, line_log[s1 + 80]}, 32'd1);
      rd(4'h4, 32'h2, "status idle after two frames");

      // Test 4: DIV=2, flood the FIFO. Writes land every 2 cycles and a
      // frame is 20 cycles, so two bytes leave during the fill: the 18th
      // write fills the FIFO and the 19th is dropped.
      wr(4'h8, 4'h3, 32'h2, "div set 2");
      c4 = cyc_n;
      for (int i = 0; i < 19; i++) wr(4'h0, 4'h1, 32'h10 + i, $sformatf("flood write %0d", i));
      rd(4'h4, 32'hD, "status full busy ovf");
      rd(4'h4, 32'h5, "status ovf cleared");
      t = 0;
      r = 32'h0;
      while (t < 300 && r !== 32'h2) begin
         bus_xfer(1'b0, 4'h4, 4'hF, 32'h0, r, k);
         t++;
      end
      chk("status drained", r, 32'h2);
      repeat (2) @(negedge clk);
      for (int i = c4; i < cyc_n - 20; ) begin
         if (line_log[i] == 1'b0) begin
            for (int j = 0; j < 8; j++) bb[j] = line_log[i + 2 * (j + 1) + 1];
            got.push_back(bb);
            i += 20;
         end else begin
            i++;
         end
      end
      chk("flood frame count", got.size(), 32'd18);
      for (int i = 0; i < 18; i++) begin
         if (i < got.size()) chk($sformatf("flood byte %0d", i), {24'b0, got[i]}, 32'h10 + i);
      end

      // Test 5: DIV raised to 8 during the start bit of a DIV=4 frame.
      wr(4'h8, 4'h3, 32'h4, "div set 4 again");
      wr(4'h0, 4'h1, 32'h55, "txdata 55 for div change");
      wait_low("div change frame starts", n0);
      wr(4'h8, 4'h3, 32'h8, "div set 8 mid frame");
      check_frame(n0, 0, 8'h55, 4, 8, s1);
      rd(4'h8, 32'h8, "div reads 8");

      // Test 6: reset during data bit 3 with a second byte queued.
      wr(4'h8, 4'h3, 32'h4, "div set 4 for reset");
      wr(4'h0, 4'h1, 32'h3C, "txdata 3C");
      wait_low("reset frame starts", n0);
      wr(4'h0, 4'h1, 32'hC3, "txdata C3 queued");
      while (cyc_n < n0 + 17) @(negedge clk);
      chk("line still in data bit 3", {31'b0, uart_tx}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("line high after reset", {31'b0, uart_tx}, 32'd1);
      rst = 1'b0;
      rd(4'h4, 32'h2, "status empty after reset");
      rd(4'h8, 32'd434, "div default after reset");
      repeat (60) @(negedge clk);
      zeros = 0;
      for (int i = n0 + 18; i < cyc_n; i++) if (line_log[i] == 1'b0) zeros++;
      chk("no frames after reset", zeros, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
